// File: rtl/dbus_if_if.sv
// Data-bus signals between the mem-stage bus master and the memory-side slave.
// The master drives the registered request fields and the timeout error pulse.
interface dbus_if_if;
  logic        bus_cyc;
  logic        bus_stb;
  logic        bus_we;
  logic [31:0] bus_adr;
  logic [3:0]  bus_sel;
  logic [31:0] bus_dat_o;
  logic [31:0] bus_dat_i;
  logic        bus_ack;
  logic        bus_err;

  modport master (
    output bus_cyc, bus_stb, bus_we, bus_adr, bus_sel, bus_dat_o, bus_err,
    input  bus_dat_i, bus_ack
  );

  modport slave (
    input  bus_cyc, bus_stb, bus_we, bus_adr, bus_sel, bus_dat_o, bus_err,
    output bus_dat_i, bus_ack
  );
endinterface

// File: rtl/dbus_if.sv
// Mem-stage data-bus master: one access in flight, strobe one cycle after the request, data on the ack cycle.
// Stalls the pipeline until ack, timeout or flush; holds read data while the pipeline itself is stalled.
module dbus_if #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             cpu_ce,
  input  logic             cpu_we,
  input  logic [31:0]      cpu_addr,
  input  logic [3:0]       cpu_sel,
  input  logic [31:0]      cpu_wdata,
  output logic [31:0]      cpu_rdata,
  output logic             stall_req,
  input  logic             pipeline_stall,
  input  logic             flush,
  dbus_if_if.master        bus
);

  localparam logic [7:0] TMO = TIMEOUT_CYCLES[7:0];

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    HOLD = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic        bus_cyc_q;
  logic        bus_stb_q;
  logic        bus_we_q;
  logic [31:0] bus_adr_q;
  logic [3:0]  bus_sel_q;
  logic [31:0] bus_dat_q;
  logic [31:0] rd_buf_q;
  logic [7:0]  cnt_q;
  logic        bus_err_d;
  logic        tmo_hit;

  assign tmo_hit = (cnt_q == TMO);

  // Handshake outputs are combinational so the ack cycle itself releases the stall.
  always_comb begin
    state_d   = state_q;
    stall_req = 1'b0;
    cpu_rdata = '0;
    bus_err_d = 1'b0;
    if (!reset) begin
      unique case (state_q)
        IDLE: begin
          stall_req = cpu_ce & ~flush;
          if (cpu_ce && !flush) state_d = BUSY;
        end
        BUSY: begin
          if (flush) begin
            state_d = IDLE;
          end else if (bus.bus_ack) begin
            cpu_rdata = bus.bus_dat_i;
            state_d   = pipeline_stall ? HOLD : IDLE;
          end else if (tmo_hit) begin
            bus_err_d = 1'b1;
            state_d   = IDLE;
          end else begin
            stall_req = 1'b1;
          end
        end
        HOLD: begin
          cpu_rdata = rd_buf_q;
          if (flush || !pipeline_stall) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= IDLE;
      bus_cyc_q <= 1'b0;
      bus_stb_q <= 1'b0;
      bus_we_q  <= 1'b0;
      bus_adr_q <= '0;
      bus_sel_q <= '0;
      bus_dat_q <= '0;
      rd_buf_q  <= '0;
      cnt_q     <= '0;
    end else begin
      state_q <= state_d;
      unique case (state_q)
        IDLE: begin
          if (cpu_ce && !flush) begin
            bus_we_q  <= cpu_we;
            bus_adr_q <= cpu_addr;
            bus_sel_q <= cpu_sel;
            bus_dat_q <= cpu_wdata;
            bus_cyc_q <= 1'b1;
            bus_stb_q <= 1'b1;
            cnt_q     <= '0;
          end
        end
        BUSY: begin
          // Flush outranks a coincident ack: the returned data never reaches rd_buf.
          if (flush) begin
            bus_cyc_q <= 1'b0;
            bus_stb_q <= 1'b0;
          end else if (bus.bus_ack) begin
            rd_buf_q  <= bus.bus_dat_i;
            bus_cyc_q <= 1'b0;
            bus_stb_q <= 1'b0;
          end else if (tmo_hit) begin
            bus_cyc_q <= 1'b0;
            bus_stb_q <= 1'b0;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.bus_cyc   = bus_cyc_q;
  assign bus.bus_stb   = bus_stb_q;
  assign bus.bus_we    = bus_we_q;
  assign bus.bus_adr   = bus_adr_q;
  assign bus.bus_sel   = bus_sel_q;
  assign bus.bus_dat_o = bus_dat_q;
  assign bus.bus_err   = bus_err_d;

  a_fields_stable: assert property (@(posedge clock) disable iff (reset)
    (state_q == BUSY && state_d == BUSY) |=> $stable({bus_we_q, bus_adr_q, bus_sel_q, bus_dat_q}));

  a_err_single: assert property (@(posedge clock) disable iff (reset)
    bus_err_d |=> !bus_err_d);

  a_cyc_stb: assert property (@(posedge clock) bus_cyc_q == bus_stb_q);

endmodule

// File: tb/tb_dbus_if.sv
// Directed bench for dbus_if with a short timeout so the abort path is reachable.
module tb_dbus_if;
  logic        clock;
  logic        reset;
  logic        cpu_ce;
  logic        cpu_we;
  logic [31:0] cpu_addr;
  logic [3:0]  cpu_sel;
  logic [31:0] cpu_wdata;
  logic [31:0] cpu_rdata;
  logic        stall_req;
  logic        pipeline_stall;
  logic        flush;
  int          n_chk;
  int          n_fail;

  dbus_if_if bus ();

  dbus_if #(.TIMEOUT_CYCLES(4)) dut (
    .clock          (clock),
    .reset          (reset),
    .cpu_ce         (cpu_ce),
    .cpu_we         (cpu_we),
    .cpu_addr       (cpu_addr),
    .cpu_sel        (cpu_sel),
    .cpu_wdata      (cpu_wdata),
    .cpu_rdata      (cpu_rdata),
    .stall_req      (stall_req),
    .pipeline_stall (pipeline_stall),
    .flush          (flush),
    .bus            (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; cpu_ce = 1'b1; cpu_we = 1'b1; cpu_addr = 32'hFFFF_FFFF;
    cpu_sel = 4'hF; cpu_wdata = 32'hFFFF_FFFF; bus.bus_ack = 1'b1; bus.bus_dat_i = 32'hFFFF_FFFF;
    step(); step(); #1;
    n_chk++; if (stall_req !== 1'b0) begin n_fail++; $display("FAIL rst_stall: got %b want 0", stall_req); end
    n_chk++; if (cpu_rdata !== 32'h0) begin n_fail++; $display("FAIL rst_rdata: got %h want 0", cpu_rdata); end
    n_chk++; if (bus.bus_err !== 1'b0) begin n_fail++; $display("FAIL rst_err: got %b want 0", bus.bus_err); end
    n_chk++; if ({bus.bus_cyc, bus.bus_stb, bus.bus_we, bus.bus_sel, bus.bus_adr, bus.bus_dat_o} !== 71'h0) begin
      n_fail++; $display("FAIL rst_bus: got %h want 0", {bus.bus_cyc, bus.bus_stb, bus.bus_we, bus.bus_sel, bus.bus_adr, bus.bus_dat_o});
    end
    reset = 1'b0; cpu_ce = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_sel = '0; cpu_wdata = '0;
    bus.bus_ack = 1'b0; bus.bus_dat_i = '0;
    step();
  endtask

  task automatic test_read_first_ack();
    cpu_ce = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h100; cpu_sel = 4'hF; bus.bus_dat_i = 32'hDEAD_BEEF; #1;
    n_chk++; if (stall_req !== 1'b1) begin n_fail++; $display("FAIL rd_idle_stall: got %b want 1", stall_req); end
    n_chk++; if (cpu_rdata !== 32'h0) begin n_fail++; $display("FAIL rd_idle_rdata: got %h want 0", cpu_rdata); end
    step();
    n_chk++; if ({bus.bus_cyc, bus.bus_stb, bus.bus_we, bus.bus_sel, bus.bus_adr} !== {1'b1, 1'b1, 1'b0, 4'hF, 32'h100}) begin
      n_fail++; $display("FAIL rd_req: got %h want %h", {bus.bus_cyc, bus.bus_stb, bus.bus_we, bus.bus_sel, bus.bus_adr}, {1'b1, 1'b1, 1'b0, 4'hF, 32'h100});
    end
    bus.bus_ack = 1'b1; #1;
    n_chk++; if (stall_req !== 1'b0) begin n_fail++; $display("FAIL rd_ack_stall: got %b want 0", stall_req); end
    n_chk++; if (cpu_rdata !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL rd_ack_rdata: got %h want deadbeef", cpu_rdata); end
    step();
    cpu_ce = 1'b0; bus.bus_ack = 1'b0; #1;
    n_chk++; if ({bus.bus_cyc, bus.bus_stb, stall_req} !== 3'b000) begin n_fail++; $display("FAIL rd_done: got %b want 000", {bus.bus_cyc, bus.bus_stb, stall_req}); end
    n_chk++; if (cpu_rdata !== 32'h0) begin n_fail++; $display("FAIL rd_done_rdata: got %h want 0", cpu_rdata); end
  endtask

  task automatic test_write_delay();
    int stalls;
    stalls = 0;
    cpu_ce = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h204; cpu_sel = 4'b0011; cpu_wdata = 32'h0000_BEEF;
    bus.bus_dat_i = 32'h1234_5678; #1;
    if (stall_req === 1'b1) stalls++;
    step();
    cpu_addr = 32'hFFF; cpu_wdata = '0; cpu_sel = 4'hF; cpu_we = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      if (stall_req === 1'b1) stalls++;
      n_chk++; if ({bus.bus_cyc, bus.bus_stb, bus.bus_we, bus.bus_sel, bus.bus_adr, bus.bus_dat_o} !== {1'b1, 1'b1, 1'b1, 4'b0011, 32'h204, 32'h0000_BEEF}) begin
        n_fail++; $display("FAIL wr_hold_%0d: got %h want %h", i, {bus.bus_cyc, bus.bus_stb, bus.bus_we, bus.bus_sel, bus.bus_adr, bus.bus_dat_o}, {1'b1, 1'b1, 1'b1, 4'b0011, 32'h204, 32'h0000_BEEF});
      end
      step();
    end
    bus.bus_ack = 1'b1; #1;
    if (stall_req === 1'b1) stalls++;
    n_chk++; if (cpu_rdata !== 32'h1234_5678) begin n_fail++; $display("FAIL wr_ack_rdata: got %h want 12345678", cpu_rdata); end
    n_chk++; if (stalls != 4) begin n_fail++; $display("FAIL wr_stall_cycles: got %0d want 4", stalls); end
    step();
    cpu_ce = 1'b0; bus.bus_ack = 1'b0; #1;
    n_chk++; if ({bus.bus_cyc, bus.bus_stb} !== 2'b00) begin n_fail++; $display("FAIL wr_cyc_drop: got %b want 00", {bus.bus_cyc, bus.bus_stb}); end
  endtask

  task automatic test_hold();
    cpu_ce = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h300; cpu_sel = 4'hF; bus.bus_dat_i = 32'hCAFE_F00D;
    step();
    bus.bus_ack = 1'b1; pipeline_stall = 1'b1; #1;
    n_chk++; if (cpu_rdata !== 32'hCAFE_F00D) begin n_fail++; $display("FAIL hold_ack_rdata: got %h want cafef00d", cpu_rdata); end
    step();
    bus.bus_dat_i = 32'h0BAD_BEEF; #1;
    n_chk++; if (cpu_rdata !== 32'hCAFE_F00D) begin n_fail++; $display("FAIL hold1_rdata: got %h want cafef00d", cpu_rdata); end
    n_chk++; if ({stall_req, bus.bus_cyc, bus.bus_stb} !== 3'b000) begin n_fail++; $display("FAIL hold1_ctl: got %b want 000", {stall_req, bus.bus_cyc, bus.bus_stb}); end
    step();
    bus.bus_ack = 1'b0; pipeline_stall = 1'b0; cpu_ce = 1'b0; #1;
    n_chk++; if (cpu_rdata !== 32'hCAFE_F00D) begin n_fail++; $display("FAIL hold2_rdata: got %h want cafef00d", cpu_rdata); end
    n_chk++; if ({stall_req, bus.bus_stb} !== 2'b00) begin n_fail++; $display("FAIL hold2_ctl: got %b want 00", {stall_req, bus.bus_stb}); end
    step(); #1;
    n_chk++; if ({cpu_rdata, bus.bus_cyc} !== 33'h0) begin n_fail++; $display("FAIL hold_exit: got %h want 0", {cpu_rdata, bus.bus_cyc}); end
  endtask

  task automatic test_timeout();
    cpu_ce = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h400; cpu_sel = 4'hF; bus.bus_dat_i = 32'h5555_5555;
    step();
    for (int i = 1; i <= 4; i++) begin
      #1;
      n_chk++; if ({stall_req, bus.bus_err, bus.bus_cyc} !== 3'b101) begin
        n_fail++; $display("FAIL tmo_busy_%0d: got %b want 101", i, {stall_req, bus.bus_err, bus.bus_cyc});
      end
      step();
    end
    #1;
    n_chk++; if ({stall_req, bus.bus_err} !== 2'b01) begin n_fail++; $display("FAIL tmo_pulse: got %b want 01", {stall_req, bus.bus_err}); end
    n_chk++; if (cpu_rdata !== 32'h0) begin n_fail++; $display("FAIL tmo_rdata: got %h want 0", cpu_rdata); end
    step();
    cpu_ce = 1'b0; #1;
    n_chk++; if ({bus.bus_cyc, bus.bus_stb, bus.bus_err} !== 3'b000) begin n_fail++; $display("FAIL tmo_after: got %b want 000", {bus.bus_cyc, bus.bus_stb, bus.bus_err}); end
    bus.bus_ack = 1'b1; bus.bus_dat_i = 32'h7777_7777; #1;
    n_chk++; if ({cpu_rdata, stall_req} !== 33'h0) begin n_fail++; $display("FAIL late_ack: got %h want 0", {cpu_rdata, stall_req}); end
    step();
    bus.bus_ack = 1'b0; #1;
    n_chk++; if (bus.bus_cyc !== 1'b0) begin n_fail++; $display("FAIL late_ack_cyc: got %b want 0", bus.bus_cyc); end
  endtask

  task automatic test_flush_ack();
    cpu_ce = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h500; cpu_sel = 4'hF; bus.bus_dat_i = 32'h9999_9999;
    step(); #1;
    n_chk++; if (stall_req !== 1'b1) begin n_fail++; $display("FAIL fl_busy1: got %b want 1", stall_req); end
    step();
    bus.bus_ack = 1'b1; flush = 1'b1; pipeline_stall = 1'b1; #1;
    n_chk++; if ({stall_req, bus.bus_err} !== 2'b00) begin n_fail++; $display("FAIL fl_cycle: got %b want 00", {stall_req, bus.bus_err}); end
    step();
    bus.bus_ack = 1'b0; flush = 1'b0; pipeline_stall = 1'b0; cpu_ce = 1'b0; #1;
    n_chk++; if ({bus.bus_cyc, bus.bus_stb, stall_req} !== 3'b000) begin n_fail++; $display("FAIL fl_idle: got %b want 000", {bus.bus_cyc, bus.bus_stb, stall_req}); end
    n_chk++; if (cpu_rdata !== 32'h0) begin n_fail++; $display("FAIL fl_discard: got %h want 0", cpu_rdata); end
  endtask

  task automatic test_flush_idle();
    cpu_ce = 1'b1; flush = 1'b1; cpu_addr = 32'h580; #1;
    n_chk++; if (stall_req !== 1'b0) begin n_fail++; $display("FAIL fli_stall: got %b want 0", stall_req); end
    step();
    cpu_ce = 1'b0; flush = 1'b0; #1;
    n_chk++; if (bus.bus_stb !== 1'b0) begin n_fail++; $display("FAIL fli_nostb: got %b want 0", bus.bus_stb); end
  endtask

  task automatic test_reset_mid_busy();
    cpu_ce = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h600; cpu_sel = 4'hC; cpu_wdata = 32'hA5A5_A5A5;
    step();
    reset = 1'b1; #1;
    n_chk++; if ({stall_req, cpu_rdata} !== 33'h0) begin n_fail++; $display("FAIL rmb_comb: got %h want 0", {stall_req, cpu_rdata}); end
    step();
    n_chk++; if ({bus.bus_cyc, bus.bus_stb, bus.bus_we, bus.bus_sel, bus.bus_adr, bus.bus_dat_o} !== 71'h0) begin
      n_fail++; $display("FAIL rmb_bus: got %h want 0", {bus.bus_cyc, bus.bus_stb, bus.bus_we, bus.bus_sel, bus.bus_adr, bus.bus_dat_o});
    end
    reset = 1'b0; cpu_ce = 1'b0;
    step();
    cpu_ce = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h700; cpu_sel = 4'hF; bus.bus_dat_i = 32'h1357_9BDF; #1;
    n_chk++; if (stall_req !== 1'b1) begin n_fail++; $display("FAIL rmb_new_stall: got %b want 1", stall_req); end
    step();
    n_chk++; if ({bus.bus_cyc, bus.bus_adr} !== {1'b1, 32'h700}) begin n_fail++; $display("FAIL rmb_new_req: got %h want %h", {bus.bus_cyc, bus.bus_adr}, {1'b1, 32'h700}); end
    bus.bus_ack = 1'b1; #1;
    n_chk++; if (cpu_rdata !== 32'h1357_9BDF) begin n_fail++; $display("FAIL rmb_new_rdata: got %h want 13579bdf", cpu_rdata); end
    step();
    cpu_ce = 1'b0; bus.bus_ack = 1'b0; #1;
    n_chk++; if (bus.bus_cyc !== 1'b0) begin n_fail++; $display("FAIL rmb_new_done: got %b want 0", bus.bus_cyc); end
  endtask

  initial begin
    n_chk = 0; n_fail = 0;
    reset = 1'b1; cpu_ce = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_sel = '0; cpu_wdata = '0;
    pipeline_stall = 1'b0; flush = 1'b0; bus.bus_ack = 1'b0; bus.bus_dat_i = '0;
    test_reset();
    test_read_first_ack();
    test_write_delay();
    test_hold();
    test_timeout();
    test_flush_ack();
    test_flush_idle();
    test_reset_mid_busy();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
